// File: rtl/bulk_in_packetizer_pkg.sv
// Shared definitions for the bulk IN packetizer: FSM states and DATA PIDs.
package bulk_in_packetizer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        READY   = 3'd2,
        SEND    = 3'd3,
        WAIT_HS = 3'd4
    } state_t;

    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;

    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? DATA1 : DATA0;
    endfunction

endpackage

// File: rtl/bulk_in_packetizer_pkt_ram.sv
// Packet buffer: one write port, one registered read port with read enable,
// so the read data holds while the consumer stalls.
module bulk_pkt_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              bulk_ep_in_clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge bulk_ep_in_clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bulk_in_packetizer.sv
// Bulk IN packetizer: drains the endpoint FIFO into a packet buffer, serves one
// packet per IN token, keeps it for retransmission and tracks the DATA toggle.
module bulk_in_packetizer
    import bulk_in_packetizer_pkg::*;
#(
    parameter int MAX_PACKET_SIZE = 512,
    parameter bit ZLP_EN          = 1'b1,
    parameter int LEN_W           = $clog2(MAX_PACKET_SIZE + 1)
) (
    input  logic       bulk_ep_in_clock,
    input  logic       reset_n,
    input  logic       ep_has_data_i,
    output logic       ep_xfer_o,
    input  logic       s_tvalid_i,
    output logic       s_tready_o,
    input  logic       s_tlast_i,
    input  logic [7:0] s_tdata_i,
    input  logic       in_token_i,
    output logic       nak_o,
    output logic       tx_tvalid_o,
    input  logic       tx_tready_i,
    output logic       tx_tlast_o,
    output logic       tx_tzero_o,
    output logic [7:0] tx_tdata_o,
    output logic [3:0] tx_pid_o,
    input  logic       hs_ack_i,
    input  logic       hs_timeout_i,
    input  logic       toggle_clr_i
);

    localparam int              ADDR_W  = $clog2(MAX_PACKET_SIZE);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PACKET_SIZE);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   tx_idx;
    logic               toggle;
    logic               zlp_pending;
    logic               last_seen;
    logic               nak_q;
    logic [3:0]         pid_q;

    logic               fill_beat;
    logic               fill_done;
    logic               tx_beat;
    logic               tx_last;
    logic               ram_re;
    logic [ADDR_W-1:0]  ram_raddr;
    logic [7:0]         ram_rdata;

    assign fill_beat = (state == FILL) && s_tvalid_i;
    assign fill_done = fill_beat && (s_tlast_i || ((len + LEN_ONE) == LEN_MAX));
    assign tx_last   = (len == '0) || (tx_idx == (len - LEN_ONE));
    assign tx_beat   = (state == SEND) && tx_tready_i;

    // Read at the token so byte 0 is ready one cycle later, then prefetch on
    // each accepted beat; with no read the RAM output holds during stalls.
    assign ram_re    = ((state == READY) && in_token_i) || (tx_beat && !tx_last);
    assign ram_raddr = (state == SEND) ? ADDR_W'(tx_idx + LEN_ONE) : '0;

    bulk_pkt_ram #(
        .DEPTH  (MAX_PACKET_SIZE),
        .ADDR_W (ADDR_W)
    ) u_pkt_ram (
        .bulk_ep_in_clock (bulk_ep_in_clock),
        .we               (fill_beat),
        .waddr            (len[ADDR_W-1:0]),
        .wdata            (s_tdata_i),
        .re               (ram_re),
        .raddr            (ram_raddr),
        .rdata            (ram_rdata)
    );

    always_ff @(posedge bulk_ep_in_clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (zlp_pending) begin
                    state_nxt = READY;
                end else if (ep_has_data_i) begin
                    state_nxt = FILL;
                end
            end
            FILL:    if (fill_done) state_nxt = READY;
            READY:   if (in_token_i) state_nxt = SEND;
            SEND:    if (tx_beat && tx_last) state_nxt = WAIT_HS;
            WAIT_HS: begin
                if (hs_ack_i) begin
                    state_nxt = IDLE;
                end else if (hs_timeout_i) begin
                    state_nxt = READY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ep_xfer_o   = 1'b0;
        s_tready_o  = 1'b0;
        tx_tvalid_o = 1'b0;
        tx_tlast_o  = 1'b0;
        tx_tzero_o  = 1'b0;
        tx_tdata_o  = '0;
        case (state)
            FILL: begin
                ep_xfer_o  = 1'b1;
                s_tready_o = 1'b1;
            end
            SEND: begin
                tx_tvalid_o = 1'b1;
                tx_tlast_o  = tx_last;
                tx_tzero_o  = (len == '0);
                tx_tdata_o  = (len == '0) ? '0 : ram_rdata;
            end
            default: ;
        endcase
    end

    assign nak_o    = nak_q;
    assign tx_pid_o = pid_q;

    always_ff @(posedge bulk_ep_in_clock) begin
        if (!reset_n) begin
            len         <= '0;
            tx_idx      <= '0;
            toggle      <= 1'b0;
            zlp_pending <= 1'b0;
            last_seen   <= 1'b0;
            nak_q       <= 1'b0;
            pid_q       <= DATA0;
        end else begin
            nak_q <= in_token_i && ((state == IDLE) || (state == FILL));
            case (state)
                IDLE: begin
                    if (zlp_pending) begin
                        len         <= '0;
                        zlp_pending <= 1'b0;
                    end else if (ep_has_data_i) begin
                        len <= '0;
                    end
                end
                FILL: begin
                    if (fill_beat) begin
                        len <= len + LEN_ONE;
                        if (fill_done) begin
                            last_seen <= s_tlast_i;
                        end
                    end
                end
                READY: begin
                    if (in_token_i) begin
                        tx_idx <= '0;
                        pid_q  <= data_pid(toggle);
                    end
                end
                SEND: begin
                    if (tx_beat && !tx_last) begin
                        tx_idx <= tx_idx + LEN_ONE;
                    end
                end
                WAIT_HS: begin
                    if (hs_ack_i) begin
                        zlp_pending <= ZLP_EN && last_seen && (len == LEN_MAX);
                    end
                end
                default: ;
            endcase
            if (toggle_clr_i) begin
                toggle <= 1'b0;
            end else if ((state == WAIT_HS) && hs_ack_i) begin
                toggle <= ~toggle;
            end
        end
    end

endmodule

// File: tb/tb_bulk_in_packetizer.sv
// Directed bench for bulk_in_packetizer with 8-byte packets; a second instance
// with ZLP_EN=0 shares all inputs and is checked only where the ZLP matters.
module tb_bulk_in_packetizer;
    import bulk_in_packetizer_pkg::*;

    logic       bulk_ep_in_clock = 1'b0;
    logic       reset_n;
    logic       ep_has_data_i;
    logic       s_tvalid_i;
    logic       s_tlast_i;
    logic [7:0] s_tdata_i;
    logic       in_token_i;
    logic       tx_tready_i;
    logic       hs_ack_i;
    logic       hs_timeout_i;
    logic       toggle_clr_i;

    logic       ep_xfer_o, s_tready_o, nak_o, tx_tvalid_o, tx_tlast_o, tx_tzero_o;
    logic [7:0] tx_tdata_o;
    logic [3:0] tx_pid_o;

    logic       z_ep_xfer_o, z_s_tready_o, z_nak_o, z_tx_tvalid_o, z_tx_tlast_o, z_tx_tzero_o;
    logic [7:0] z_tx_tdata_o;
    logic [3:0] z_tx_pid_o;

    always #5 bulk_ep_in_clock = ~bulk_ep_in_clock;

    bulk_in_packetizer #(.MAX_PACKET_SIZE(8), .ZLP_EN(1'b1)) u_dut (
        .bulk_ep_in_clock(bulk_ep_in_clock), .reset_n(reset_n),
        .ep_has_data_i(ep_has_data_i), .ep_xfer_o(ep_xfer_o),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
        .in_token_i(in_token_i), .nak_o(nak_o),
        .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o),
        .tx_tzero_o(tx_tzero_o), .tx_tdata_o(tx_tdata_o), .tx_pid_o(tx_pid_o),
        .hs_ack_i(hs_ack_i), .hs_timeout_i(hs_timeout_i), .toggle_clr_i(toggle_clr_i)
    );

    bulk_in_packetizer #(.MAX_PACKET_SIZE(8), .ZLP_EN(1'b0)) u_dut_nozlp (
        .bulk_ep_in_clock(bulk_ep_in_clock), .reset_n(reset_n),
        .ep_has_data_i(ep_has_data_i), .ep_xfer_o(z_ep_xfer_o),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(z_s_tready_o), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
        .in_token_i(in_token_i), .nak_o(z_nak_o),
        .tx_tvalid_o(z_tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(z_tx_tlast_o),
        .tx_tzero_o(z_tx_tzero_o), .tx_tdata_o(z_tx_tdata_o), .tx_pid_o(z_tx_pid_o),
        .hs_ack_i(hs_ack_i), .hs_timeout_i(hs_timeout_i), .toggle_clr_i(toggle_clr_i)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] up_bytes [0:63];
    int         up_n   = 0;
    int         up_idx = 0;
    bit         up_last = 1'b0;
    logic [7:0] rx [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        ep_has_data_i = 1'b0;
        s_tvalid_i    = 1'b0;
        s_tlast_i     = 1'b0;
        s_tdata_i     = 8'h00;
        in_token_i    = 1'b0;
        tx_tready_i   = 1'b1;
        hs_ack_i      = 1'b0;
        hs_timeout_i  = 1'b0;
        toggle_clr_i  = 1'b0;
        up_n          = 0;
        up_idx        = 0;
        repeat (2) @(negedge bulk_ep_in_clock);
        reset_n = 1'b1;
        @(negedge bulk_ep_in_clock);
    endtask

    task automatic load(input int n, input logic [7:0] base, input bit last);
        up_n    = n;
        up_idx  = 0;
        up_last = last;
        for (int i = 0; i < n; i++) up_bytes[i] = base + 8'(i);
    endtask

    // Presents upstream bytes until the DUT leaves FILL after taking a packet.
    task automatic fill();
        bit entered = 1'b0;
        bit done    = 1'b0;
        bit xfer_ok = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            ep_has_data_i = (up_idx < up_n);
            s_tvalid_i    = (up_idx < up_n);
            s_tdata_i     = (up_idx < up_n) ? up_bytes[up_idx] : 8'h00;
            s_tlast_i     = up_last && (up_idx == up_n - 1);
            if (s_tready_o) begin
                entered = 1'b1;
                if (!ep_xfer_o) xfer_ok = 1'b0;
            end
            if (s_tvalid_i && s_tready_o) up_idx++;
            @(negedge bulk_ep_in_clock);
            if (entered && !s_tready_o) done = 1'b1;
        end
        s_tvalid_i    = 1'b0;
        s_tlast_i     = 1'b0;
        ep_has_data_i = (up_idx < up_n);
        check("fill_done", 32'(done), 32'd1);
        check("fill_ep_xfer_high", 32'(xfer_ok), 32'd1);
        check("fill_ep_xfer_drop", 32'(ep_xfer_o), 32'd0);
    endtask

    task automatic token(output logic nak0, output logic nak1, output logic tv);
        in_token_i = 1'b1;
        @(negedge bulk_ep_in_clock);
        in_token_i = 1'b0;
        nak0 = nak_o;
        nak1 = z_nak_o;
        tv   = tx_tvalid_o;
    endtask

    task automatic hs(input bit ack, input bit tmo, input bit clr);
        hs_ack_i     = ack;
        hs_timeout_i = tmo;
        toggle_clr_i = clr;
        @(negedge bulk_ep_in_clock);
        hs_ack_i     = 1'b0;
        hs_timeout_i = 1'b0;
        toggle_clr_i = 1'b0;
    endtask

    // Receives one packet; stalls 3 cycles on beat stall_beat (negative: none).
    task automatic collect(input int stall_beat, output int n, output logic [3:0] pid,
                           output logic zero, output bit done);
        int         stall = 0;
        logic [7:0] hold_d = 8'h00;
        logic       hold_l = 1'b0;
        n = 0; pid = 4'h0; zero = 1'b0; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (tx_tvalid_o) begin
                if (n == stall_beat && stall < 3) begin
                    tx_tready_i = 1'b0;
                    if (stall == 0) begin
                        hold_d = tx_tdata_o;
                        hold_l = tx_tlast_o;
                    end else begin
                        check("stall_data", 32'(tx_tdata_o), 32'(hold_d));
                        check("stall_last", 32'(tx_tlast_o), 32'(hold_l));
                    end
                    stall++;
                end else begin
                    if (n == stall_beat) check("stall_release_data", 32'(tx_tdata_o), 32'(hold_d));
                    tx_tready_i = 1'b1;
                    if (n < 16) rx[n] = tx_tdata_o;
                    pid  = tx_pid_o;
                    zero = zero | tx_tzero_o;
                    n++;
                    if (tx_tlast_o) begin
                        done = 1'b1;
                        @(negedge bulk_ep_in_clock);
                        break;
                    end
                end
            end
            @(negedge bulk_ep_in_clock);
        end
        tx_tready_i = 1'b1;
    endtask

    task automatic expect_pkt(input int exp_n, input logic [7:0] base, input logic [3:0] exp_pid,
                              input int stall_beat, input string tag);
        logic       n0, n1, tv, zero;
        logic [3:0] pid;
        int         n;
        bit         done;
        token(n0, n1, tv);
        check({tag, "_nak"}, 32'(n0), 32'd0);
        check({tag, "_latency"}, 32'(tv), 32'd1);
        collect(stall_beat, n, pid, zero, done);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_len"}, 32'(n), 32'(exp_n));
        check({tag, "_pid"}, 32'(pid), 32'(exp_pid));
        check({tag, "_tzero"}, 32'(zero), 32'd0);
        for (int i = 0; i < exp_n && i < n && i < 16; i++)
            check({tag, "_byte"}, 32'(rx[i]), 32'(base + 8'(i)));
    endtask

    initial begin
        logic       n0, n1, tv, zero;
        logic [3:0] pid;
        int         n;
        bit         done;

        do_reset();
        check("rst_pid", 32'(tx_pid_o), 32'(DATA0));
        check("rst_tvalid", 32'(tx_tvalid_o), 32'd0);
        check("rst_tready", 32'(s_tready_o), 32'd0);
        check("rst_xfer", 32'(ep_xfer_o), 32'd0);
        check("rst_nak", 32'(nak_o), 32'd0);
        check("rst_tlast_tzero_data", {tx_tlast_o, tx_tzero_o, tx_tdata_o}, 32'd0);

        // 5 bytes with tlast, then retransmit and ack/timeout collision
        load(5, 8'h01, 1'b1);
        fill();
        expect_pkt(5, 8'h01, DATA0, -1, "s1");
        hs(1'b1, 1'b0, 1'b0);
        load(3, 8'hA0, 1'b1);
        fill();
        expect_pkt(3, 8'hA0, DATA1, -1, "s4_first");
        hs(1'b0, 1'b1, 1'b0);
        @(negedge bulk_ep_in_clock);
        check("s4_tready_low", 32'(s_tready_o), 32'd0);
        expect_pkt(3, 8'hA0, DATA1, -1, "s4_retx");
        hs(1'b1, 1'b1, 1'b0);
        load(2, 8'hB0, 1'b1);
        fill();
        expect_pkt(2, 8'hB0, DATA0, -1, "s4_ack_wins");
        hs(1'b1, 1'b0, 1'b0);

        // 20 bytes: 8/8/4, no ZLP afterwards
        do_reset();
        load(20, 8'h10, 1'b1);
        fill();
        expect_pkt(8, 8'h10, DATA0, -1, "s2_p0");
        hs(1'b1, 1'b0, 1'b0);
        fill();
        expect_pkt(8, 8'h18, DATA1, -1, "s2_p1");
        hs(1'b1, 1'b0, 1'b0);
        fill();
        expect_pkt(4, 8'h20, DATA0, -1, "s2_p2");
        hs(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge bulk_ep_in_clock);
        token(n0, n1, tv);
        check("s2_no_zlp_nak", 32'(n0), 32'd1);
        check("s2_no_zlp_tvalid", 32'(tv), 32'd0);

        // 16 bytes: two full packets then a ZLP (NAK when ZLP_EN=0)
        do_reset();
        load(16, 8'h30, 1'b1);
        fill();
        expect_pkt(8, 8'h30, DATA0, -1, "s3_p0");
        hs(1'b1, 1'b0, 1'b0);
        fill();
        expect_pkt(8, 8'h38, DATA1, -1, "s3_p1");
        hs(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge bulk_ep_in_clock);
        token(n0, n1, tv);
        check("s3_zlp_nak", 32'(n0), 32'd0);
        check("s3_nozlp_nak", 32'(n1), 32'd1);
        check("s3_zlp_latency", 32'(tv), 32'd1);
        collect(-1, n, pid, zero, done);
        check("s3_zlp_done", 32'(done), 32'd1);
        check("s3_zlp_beats", 32'(n), 32'd1);
        check("s3_zlp_tzero", 32'(zero), 32'd1);
        check("s3_zlp_pid", 32'(pid), 32'(DATA0));
        hs(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge bulk_ep_in_clock);
        token(n0, n1, tv);
        check("s3_after_zlp_nak", 32'(n0), 32'd1);

        // NAK in IDLE, then a stalled packet
        @(negedge bulk_ep_in_clock);
        token(n0, n1, tv);
        check("s5_idle_nak", 32'(n0), 32'd1);
        check("s5_idle_tvalid", 32'(tv), 32'd0);
        @(negedge bulk_ep_in_clock);
        check("s5_nak_pulse_end", 32'(nak_o), 32'd0);
        check("s5_tvalid_still_low", 32'(tx_tvalid_o), 32'd0);
        load(6, 8'h50, 1'b1);
        fill();
        expect_pkt(6, 8'h50, DATA1, 2, "s5_stall");
        hs(1'b1, 1'b0, 1'b0);

        // reset mid-SEND with toggle at 1, then toggle_clr alongside ack
        load(2, 8'h70, 1'b1);
        fill();
        expect_pkt(2, 8'h70, DATA0, -1, "s6_pre");
        hs(1'b1, 1'b0, 1'b0);
        load(4, 8'h60, 1'b1);
        fill();
        token(n0, n1, tv);
        check("s6_send_started", 32'(tv), 32'd1);
        check("s6_send_pid", 32'(tx_pid_o), 32'(DATA1));
        reset_n = 1'b0;
        @(negedge bulk_ep_in_clock);
        check("s6_rst_tvalid", 32'(tx_tvalid_o), 32'd0);
        check("s6_rst_pid", 32'(tx_pid_o), 32'(DATA0));
        check("s6_rst_others", {ep_xfer_o, s_tready_o, nak_o, tx_tlast_o, tx_tzero_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge bulk_ep_in_clock);
        load(2, 8'h80, 1'b1);
        fill();
        expect_pkt(2, 8'h80, DATA0, -1, "s6_after_rst");
        hs(1'b1, 1'b0, 1'b1);
        load(2, 8'h90, 1'b1);
        fill();
        expect_pkt(2, 8'h90, DATA0, -1, "s6_clr");
        hs(1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
